// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: WIDTH bits split into STAGES carry segments, one segment per stage,
// with a global stall driven by the valid/ready handshake at the output.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int SEG = WIDTH / STAGES;

    logic             en;
    logic             last_valid;
    logic [WIDTH-1:0] last_res;
    logic             last_carry;
    logic             last_cmsb;

    // Carry-lookahead add of one segment: every carry is a flat sum of generate/propagate terms.
    function automatic logic [SEG:0] cla_add(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                             input logic c0);
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG:0]   c;
        logic           term;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < SEG; i++) begin
            term = c0;
            for (int j = 0; j <= i; j++) term = term & p[j];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[SEG], p ^ c[SEG-1:0]};
    endfunction

    assign en       = !last_valid || out_ready;
    assign in_ready = en;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int OPW = WIDTH - gi * SEG;  // operand bits not yet added
        localparam int LOW = gi * SEG;          // result bits already finished

        logic               v_in;
        logic               c_in;
        logic [OPW-1:0]     a_in;
        logic [OPW-1:0]     b_in;
        logic [SEG:0]       seg_sum;
        logic               valid_reg;
        logic               carry_reg;
        logic [LOW+SEG-1:0] res_reg;

        if (gi == 0) begin : g_first
            assign v_in = in_valid;
            assign c_in = cin;
            assign a_in = a;
            assign b_in = sub ? ~b : b;

            always_ff @(posedge clk) begin
                if (!rst_n) res_reg <= '0;
                else if (en) res_reg <= seg_sum[SEG-1:0];
            end
        end else begin : g_next
            assign v_in = g_stage[gi-1].valid_reg;
            assign c_in = g_stage[gi-1].carry_reg;
            assign a_in = g_stage[gi-1].g_fwd.a_hi;
            assign b_in = g_stage[gi-1].g_fwd.b_hi;

            always_ff @(posedge clk) begin
                if (!rst_n) res_reg <= '0;
                else if (en) res_reg <= {seg_sum[SEG-1:0], g_stage[gi-1].res_reg};
            end
        end

        assign seg_sum = cla_add(a_in[SEG-1:0], b_in[SEG-1:0], c_in);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                carry_reg <= 1'b0;
            end else if (en) begin
                valid_reg <= v_in;
                carry_reg <= seg_sum[SEG];
            end
        end

        if (gi < STAGES - 1) begin : g_fwd
            logic [OPW-SEG-1:0] a_hi;
            logic [OPW-SEG-1:0] b_hi;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_hi <= '0;
                    b_hi <= '0;
                end else if (en) begin
                    a_hi <= a_in[OPW-1:SEG];
                    b_hi <= b_in[OPW-1:SEG];
                end
            end
        end else begin : g_last
            logic cmsb_reg;

            // Carry into the MSB, recovered from the MSB's own sum bit.
            always_ff @(posedge clk) begin
                if (!rst_n) cmsb_reg <= 1'b0;
                else if (en) cmsb_reg <= a_in[SEG-1] ^ b_in[SEG-1] ^ seg_sum[SEG-1];
            end

            assign last_valid = valid_reg;
            assign last_res   = res_reg;
            assign last_carry = carry_reg;
            assign last_cmsb  = cmsb_reg;
        end
    end

    assign out_valid = last_valid;
    assign sum       = last_res;
    assign cout      = last_carry;
    assign ovf       = last_cmsb ^ last_carry;
    // Qualified by valid so an empty pipe reports all-zero flags rather than zero=1.
    assign zero      = last_valid & ~|last_res;
    assign neg       = last_res[WIDTH-1];
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: driver pushes expected results on acceptance, monitor pops on each output handshake.
module tb_pipelined_adder;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready;
    logic        cout, ovf, zero, neg;
    logic [31:0] a, b, sum;

    logic        iv8, rdy4, rdy1, ov4, ov1, co4, co1, of4, of1, z4, z1, n4, n1;
    logic [7:0]  a8, b8, s4, s1;

    pipelined_adder #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg));

    pipelined_adder #(.WIDTH(8), .STAGES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy4),
        .a(a8), .b(b8), .cin(1'b0), .sub(1'b0), .out_valid(ov4), .out_ready(1'b1),
        .sum(s4), .cout(co4), .ovf(of4), .zero(z4), .neg(n4));

    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy1),
        .a(a8), .b(b8), .cin(1'b0), .sub(1'b0), .out_valid(ov1), .out_ready(1'b1),
        .sum(s1), .cout(co1), .ovf(of1), .zero(z1), .neg(n1));

    typedef struct {
        logic [31:0] sum;
        logic        cout, ovf, zero, neg;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rand_ready = 0;
    logic prev_stall = 0;
    logic [35:0] prev_out;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the effective operands.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic c,
                                   input logic s);
        exp_t        r;
        logic [31:0] bx;
        logic [32:0] full;
        bx        = s ? ~y : y;
        full      = {1'b0, x} + {1'b0, bx} + 33'(c);
        r.sum     = full[31:0];
        r.cout    = full[32];
        r.ovf     = (x[31] == bx[31]) && (r.sum[31] != x[31]);
        r.zero    = (r.sum == 32'd0);
        r.neg     = r.sum[31];
        r.acc     = 0;
        r.chk_lat = 0;
        return r;
    endfunction

    function automatic exp_t lit(input logic [31:0] s, input logic c, input logic o,
                                 input logic z, input logic n);
        exp_t r;
        r.sum = s; r.cout = c; r.ovf = o; r.zero = z; r.neg = n;
        r.acc = 0; r.chk_lat = 1;
        return r;
    endfunction

    // Present one operand set from posedge+1; returns at posedge+1 after it was accepted.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic c,
                         input logic s, input exp_t e);
        a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.acc = cyc + 1;
                q.push_back(e);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (prev_stall) check("stall_hold", 64'({sum, cout, ovf, zero, neg}), 64'(prev_out));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 64'(sum), 64'hDEAD_0000_0000);
                end else begin
                    mon_e = q.pop_front();
                    check("sum", 64'(sum), 64'(mon_e.sum));
                    check("flags", 64'({cout, ovf, zero, neg}),
                          64'({mon_e.cout, mon_e.ovf, mon_e.zero, mon_e.neg}));
                    if (mon_e.chk_lat) check("latency", 64'(cyc - mon_e.acc), 64'd1);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {sum, cout, ovf, zero, neg};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic small_vec(input logic [7:0] x, input logic [7:0] y, input logic [7:0] es,
                             input logic ec, input logic eo, input logic ez);
        int lat4 = -1;
        int lat1 = -1;
        check("s4_in_ready", 64'(rdy4), 64'd1);
        check("s1_in_ready", 64'(rdy1), 64'd1);
        a8 = x; b8 = y; iv8 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            iv8 = 1'b0;
            if (ov4 && lat4 < 0) begin
                lat4 = k;
                check("s4_result", 64'({s4, co4, of4, z4}), 64'({es, ec, eo, ez}));
            end
            if (ov1 && lat1 < 0) begin
                lat1 = k;
                check("s1_result", 64'({s1, co1, of1, z1}), 64'({es, ec, eo, ez}));
            end
        end
        check("s4_latency", 64'(lat4), 64'd4);
        check("s1_latency", 64'(lat1), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({out_valid, sum, cout, ovf, zero, neg}), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Known-answer vectors through an empty pipe
        issue(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, lit(32'h0, 1, 0, 1, 0));          idle(3);
        issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lit(32'h8000_0000, 0, 1, 0, 1));  idle(3);
        issue(32'd5, 32'd7, 1'b1, 1'b1, lit(32'hFFFF_FFFE, 0, 0, 0, 1));          idle(3);
        issue(32'd7, 32'd5, 1'b1, 1'b1, lit(32'd2, 1, 0, 0, 0));                  idle(3);

        // Back-pressure: i+i stream with a 3-cycle stall mid-stream
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    exp_t e;
                    e = lit(32'(2 * i), 0, 0, 0, 0);
                    e.chk_lat = 0;
                    issue(32'(i), 32'(i), 1'b0, 1'b0, e);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(6);
        check("bp_drained", 64'(q.size()), 64'd0);

        // Reset with two operations in flight
        issue($urandom, $urandom, 1'b0, 1'b0, model(32'h0, 32'h0, 1'b0, 1'b0));
        issue($urandom, $urandom, 1'b0, 1'b0, model(32'h0, 32'h0, 1'b0, 1'b0));
        in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_outputs", 64'({out_valid, sum, cout, ovf, zero, neg}), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1; out_ready = 1'b1;
        q.delete();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("no_stale_result", 64'(out_valid), 64'd0);
        end

        // Randomised traffic with random back-pressure
        rand_ready = 1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                logic [31:0] x, y;
                logic        c, s;
                x = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                y = ($urandom_range(0, 7) == 0) ? x : $urandom;
                c = 1'($urandom);
                s = 1'($urandom);
                issue(x, y, c, s, model(x, y, c, s));
            end
        end
        in_valid = 1'b0;
        rand_ready = 0;
        out_ready = 1'b1;
        idle(6);
        check("random_drained", 64'(q.size()), 64'd0);

        // Narrow configurations: 4 stages and single stage
        small_vec(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        small_vec(8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined add/subtract unit that replaces the fixed 32-bit two-segment combinational adder in the datapath. It splits a WIDTH-bit operation into STAGES equal carry segments and registers the carry between segments, so throughput is one operation per clock. It also adds a subtract mode and status flags. It sits between the ALU operand latches and the writeback mux, and uses a valid/ready handshake so writeback can stall it.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 2, number of pipeline stages; each stage adds one segment of SEG = WIDTH/STAGES bits; allowed range 1..WIDTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand set presented.
- in_ready  out  1  unit accepts an operand set this cycle.
- a, b  in  WIDTH  operands.
- cin  in  1  carry-in; in subtract mode it is the inverted borrow.
- sub  in  1  0: a+b+cin; 1: a+~b+cin.
- out_valid  out  1  result held on the outputs.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB.
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.
- neg  out  1  sum[WIDTH-1].

## Operation
- Stage 0 captures the operands, computes segment 0 (bits SEG-1:0) with the carry-in, and registers:
  - segment 0 result;
  - carry out of segment 0;
  - upper operand bits, with b already conditionally inverted.
- Stage k (1..STAGES-1) adds segment k using the registered carry from stage k-1 and forwards all lower result bits unchanged.
- Segments are added with carry-lookahead inside the segment; there is no combinational carry path between stages.
- Each stage has its own valid bit. Bubbles travel down the pipe as invalid slots.
- Global advance: en = !out_valid || out_ready; in_ready = en.
  - When en = 1, every stage register loads from its predecessor, including invalid slots.
  - When en = 0, all stages hold.
  - Bubbles are not collapsed.
- An operand set is accepted when in_valid && in_ready. If in_valid = 0 while en = 1, stage 0 loads an invalid slot.
- Flags are computed combinationally in the last stage from the final-stage registers:
  - cout = carry out of bit WIDTH-1;
  - ovf = carry into bit WIDTH-1 XOR cout;
  - zero = ~|sum;
  - neg = sum[WIDTH-1].
  - In subtract mode the flags refer to a+~b+cin. With cin = 1 this is a-b, and cout = 1 means no borrow.
- STAGES = 1: the block is one registered adder with latency 1.
- Outputs sum and flags are only meaningful while out_valid = 1. They must still be deterministic (all registers reset).

## Timing
- Reset: when rst_n = 0 at a rising edge, the following clear to 0 in that cycle: every stage valid bit, every data register, out_valid, sum, cout, ovf, zero, neg.
  - in_ready = 1 from the first cycle after reset.
  - A reset while operations are in flight discards them all; no result from before the reset ever appears.
- Latency: an operand set accepted at edge N appears with out_valid = 1 after edge N+STAGES-1. It is presented to the consumer from the cycle following that edge, provided en stayed 1.
- Each stall cycle (out_valid && !out_ready) adds one cycle of latency to every in-flight operation.
- Throughput: one result per cycle while out_ready = 1.
- Output stability: while out_valid && !out_ready, sum, cout, ovf, zero and neg hold constant.
- Simultaneous events: when out_valid && out_ready and a new set is accepted in the same cycle, both happen. Nothing is lost and nothing is duplicated.
- Results leave in acceptance order.

## Test plan
- WIDTH=32, STAGES=2:
  - Stimulus: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, out_ready=1.
  - Required response: after 2 cycles, sum=0x00000000, cout=1, zero=1, ovf=0, neg=0. The carry crosses the stage boundary.
- WIDTH=32:
  - Stimulus: a=0x7FFFFFFF, b=0x00000001, add.
  - Required response: sum=0x80000000, ovf=1, neg=1, cout=0.
- WIDTH=32, subtract mode:
  - Stimulus: a=5, b=7, sub=1, cin=1.
  - Required response: sum=0xFFFFFFFE, cout=0 (borrow), neg=1, ovf=0.
  - Stimulus: a=7, b=5.
  - Required response: sum=2, cout=1.
- Back-pressure:
  - Stimulus: stream operands i+i for i=1..6; drop out_ready for 3 cycles mid-stream.
  - Required response: results 2, 4, 6, 8, 10, 12 in order with none lost or duplicated. in_ready = 0 exactly while out_valid && !out_ready. Outputs hold stable during the stall.
- Reset mid-flight:
  - Stimulus: accept 2 operations, then assert rst_n=0 for 1 cycle.
  - Required response: out_valid and all outputs are 0 after the reset edge. No pre-reset result ever appears. in_ready = 1 on the next cycle.
- WIDTH=8, STAGES=4:
  - Stimulus: a=0xFF, b=0x01, cin=0.
  - Required response: sum=0x00, cout=1, latency 4 cycles.
- WIDTH=8, STAGES=1:
  - Stimulus: a=0x80, b=0x80.
  - Required response: sum=0x00, cout=1, ovf=1, latency 1 cycle.
